// File: rtl/banco_registro_param.sv
// banco_registro_param: parametrised register file with one write port,
// NRD registered read ports, write-first bypass and a clear sequencer that
// zeroes every entry over DEPTH cycles after a single clr pulse.
// Optional build macro ZERO_REG_EN: entry 0 hardwired to zero.
module banco_registro_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NRD    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        addr_rd,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [NRD*ADDR_W-1:0]    addr_rs,
  output logic [NRD*DATA_W-1:0]    rs,
  input  logic                     clr,
  output logic                     busy
);

  localparam int unsigned      DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  LAST  = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state, state_n;
  logic [ADDR_W:0]       cnt, cnt_n;
  logic [ADDR_W-1:0]     cnt_idx;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     rd_next [NRD];
  logic                  wr_ok;
  logic                  clearing;

  assign clearing = (state == CLEAR);
  assign cnt_idx  = cnt[ADDR_W-1:0];
  assign busy     = clearing;

`ifdef ZERO_REG_EN
  assign wr_ok = we && !clearing && (addr_rd != '0);
`else
  assign wr_ok = we && !clearing;
`endif

  // State and sweep counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic: IDLE waits for clr, CLEAR walks cnt up to DEPTH-1
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (clr) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      CLEAR: begin
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Storage array: accepted writes in IDLE, zeroing of entry cnt in CLEAR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem[addr_rd] <= data_in;
      end
      if (clearing) begin
        mem[cnt_idx] <= '0;
      end
    end
  end

  // Per-port read data with write-first and sweep bypass resolved independently
  always_comb begin
    for (int unsigned k = 0; k < NRD; k++) begin
      rd_next[k] = mem[addr_rs[k*ADDR_W +: ADDR_W]];
      if (wr_ok && (addr_rd == addr_rs[k*ADDR_W +: ADDR_W])) begin
        rd_next[k] = data_in;
      end
      if (clearing && (cnt_idx == addr_rs[k*ADDR_W +: ADDR_W])) begin
        rd_next[k] = '0;
      end
`ifdef ZERO_REG_EN
      if (addr_rs[k*ADDR_W +: ADDR_W] == '0) begin
        rd_next[k] = '0;
      end
`endif
    end
  end

  // Registered read ports, one cycle latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs <= '0;
    end else begin
      for (int unsigned k = 0; k < NRD; k++) begin
        rs[k*DATA_W +: DATA_W] <= rd_next[k];
      end
    end
  end

endmodule
